// File: rtl/taiga_types.sv
// Shared Taiga type definitions plus the entry and state types used by the
// RCA issue queue (rca_issue_queue).
package taiga_types;

    // Existing core constants
    localparam int NUM_RCAS       = 4;
    localparam int NUM_READ_PORTS = 3;
    localparam int XLEN           = 32;
    localparam int RCA_SEL_W      = $clog2(NUM_RCAS);

    typedef logic [3:0] id_t;

    // One queued RCA use instruction
    typedef struct packed {
        id_t                                  id;
        logic [RCA_SEL_W-1:0]                 rca_sel;
        logic                                 fb;
        logic [NUM_READ_PORTS-1:0][XLEN-1:0]  rs_data;
    } rca_issue_entry_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } rca_issue_queue_state_t;

endpackage

// File: rtl/rca_issue_queue.sv
// rca_issue_queue: in-order queue between CPU issue of RCA use instructions
// and the RCA grid control / writeback path. Entries are dispatched to the
// grid one per cycle; dispatched entries stay until writeback commits them.
// A switch to a different RCA waits (DRAIN) until every dispatched entry of
// the running RCA has committed.
// Optional build macro: RCA_ISSUE_QUEUE_PERF_EN adds saturating performance
// counters perf_drain_cycles and perf_full_cycles.
module rca_issue_queue
    import taiga_types::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic                                 clk,
    input  logic                                 rst,

    input  logic                                 issue_valid,
    output logic                                 issue_ready,
    input  id_t                                  issue_id,
    input  logic [RCA_SEL_W-1:0]                 issue_rca_sel,
    input  logic                                 issue_fb,
    input  logic [NUM_READ_PORTS-1:0][XLEN-1:0]  issue_rs_data,

    output logic [NUM_READ_PORTS-1:0][XLEN-1:0]  buf_rs_data,
    output logic                                 buf_rs_data_valid,
    output logic [RCA_SEL_W-1:0]                 rca_sel_buf,
    output logic [RCA_SEL_W-1:0]                 currently_running_rca,

    input  logic                                 wb_committing,
    output id_t                                  wb_id,
    output logic                                 wb_fb_instr,
    output logic                                 fifo_populated,

    input  logic                                 clear,
`ifdef RCA_ISSUE_QUEUE_PERF_EN
    output logic [31:0]                          perf_drain_cycles,
    output logic [31:0]                          perf_full_cycles,
`endif
    output logic                                 protocol_err
);

    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    rca_issue_entry_t        mem [DEPTH];
    rca_issue_entry_t        issue_entry;

    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        disp_ptr;
    logic [PTR_W-1:0]        cm_ptr;
    logic [CNT_W-1:0]        count;
    logic [CNT_W-1:0]        outstanding;
    logic [CNT_W-1:0]        count_next;
    logic [CNT_W-1:0]        outstanding_next;
    rca_issue_queue_state_t  state;

    logic                    accept;
    logic                    has_undispatched;
    logic                    same_rca;
    logic                    dispatch;
    logic                    commit;
    logic                    drain_needed;

    assign issue_entry = '{
        id:      issue_id,
        rca_sel: issue_rca_sel,
        fb:      issue_fb,
        rs_data: issue_rs_data
    };

    // Handshake and pipeline decisions; ready uses the pre-commit count.
    assign issue_ready      = (count != FULL_COUNT);
    assign accept           = issue_valid && issue_ready && !clear;
    assign has_undispatched = (count != outstanding);
    assign same_rca         = (mem[disp_ptr].rca_sel == currently_running_rca);
    assign dispatch         = has_undispatched && (state != DRAIN) &&
                              ((outstanding == '0) || same_rca) && !clear;
    assign commit           = wb_committing && (outstanding != '0) && !clear;
    assign drain_needed     = has_undispatched && (outstanding != '0) && !same_rca;

    assign count_next       = count + CNT_W'(accept) - CNT_W'(commit);
    assign outstanding_next = outstanding + CNT_W'(dispatch) - CNT_W'(commit);

    assign fifo_populated   = (count != '0);
    assign rca_sel_buf      = has_undispatched ? mem[disp_ptr].rca_sel : '0;
    assign wb_id            = mem[cm_ptr].id;
    assign wb_fb_instr      = mem[cm_ptr].fb;

    // Entry storage written on accept.
    // NOTE: storage has no reset; pointers and counts alone define which
    // entries are valid, so resetting the array would only cost flops.
    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= issue_entry;
    end

    // Pointers, counters, dispatch output registers and the IDLE/RUN/DRAIN FSM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr                <= '0;
            disp_ptr              <= '0;
            cm_ptr                <= '0;
            count                 <= '0;
            outstanding           <= '0;
            state                 <= IDLE;
            buf_rs_data           <= '0;
            buf_rs_data_valid     <= 1'b0;
            currently_running_rca <= '0;
            protocol_err          <= 1'b0;
        end else begin
            // Commit with nothing dispatched is a sticky protocol violation.
            if (wb_committing && (outstanding == '0)) protocol_err <= 1'b1;

            if (clear) begin
                wr_ptr            <= '0;
                disp_ptr          <= '0;
                cm_ptr            <= '0;
                count             <= '0;
                outstanding       <= '0;
                state             <= IDLE;
                buf_rs_data_valid <= 1'b0;
            end else begin
                if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
                if (commit) cm_ptr <= cm_ptr + PTR_W'(1);
                if (dispatch) begin
                    disp_ptr              <= disp_ptr + PTR_W'(1);
                    buf_rs_data           <= mem[disp_ptr].rs_data;
                    currently_running_rca <= mem[disp_ptr].rca_sel;
                end
                buf_rs_data_valid <= dispatch;
                count             <= count_next;
                outstanding       <= outstanding_next;

                case (state)
                    IDLE:    if (accept) state <= RUN;
                    RUN: begin
                        if (count_next == '0)  state <= IDLE;
                        else if (drain_needed) state <= DRAIN;
                    end
                    DRAIN:   if (outstanding == '0) state <= RUN;
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef RCA_ISSUE_QUEUE_PERF_EN
    // Saturating residency counters, cleared only by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_drain_cycles <= '0;
            perf_full_cycles  <= '0;
        end else begin
            if ((state == DRAIN) && (perf_drain_cycles != '1))
                perf_drain_cycles <= perf_drain_cycles + 32'd1;
            if (issue_valid && !issue_ready && (perf_full_cycles != '1))
                perf_full_cycles <= perf_full_cycles + 32'd1;
        end
    end
`endif

endmodule
